// File: rtl/dly_calib_capture_pkg.sv
// Shared constants, state encoding and saturating helpers for the
// delay-line calibration capture block.
// Optional feature macro: DLY_CALIB_MINMAX_EN (adds min/max code tracking).
package dly_calib_capture_pkg;

    localparam int BITS_FINE       = 8;
    localparam int BITS_DLY_SWITCH = 25;
    localparam int CNT_DLY_CALIB   = 5;
    localparam int TIMEOUT         = 6;
    localparam int BITS_SUM        = BITS_FINE + CNT_DLY_CALIB;
    localparam int CALIB_PERIOD    = 8;
    localparam int TIMER_W         = 3;

    // Controller command codes shared with the calibration sequencer.
    localparam logic [1:0] CMD_NOP       = 2'b00;
    localparam logic [1:0] CMD_DLY_CALIB = 2'b01;
    localparam logic [1:0] CMD_PIX_CALIB = 2'b10;
    localparam logic [1:0] CMD_RUN       = 2'b11;

    // Capture state encodings as seen by the controller status readback.
    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_ARMED    = 2'b01;
    localparam logic [1:0] ST_WAIT_RES = 2'b10;
    localparam logic [1:0] ST_DONE     = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ARMED    = ST_ARMED,
        WAIT_RES = ST_WAIT_RES,
        DONE     = ST_DONE
    } calib_state_t;

    // Highest legal register-file index and the last timer value before a miss.
    localparam logic [CNT_DLY_CALIB-1:0] LAST_ENTRY = CNT_DLY_CALIB'(BITS_DLY_SWITCH - 1);
    localparam logic [TIMER_W-1:0]       TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    // Count-style statistics stop at all-ones instead of wrapping.
    function automatic logic [CNT_DLY_CALIB-1:0] sat_inc_cnt(input logic [CNT_DLY_CALIB-1:0] value);
        logic [CNT_DLY_CALIB-1:0] result;
        result = (&value) ? value : value + 1'b1;
        return result;
    endfunction

    // Accumulator add that clamps at all-ones on carry out.
    function automatic logic [BITS_SUM-1:0] sat_add_sum(input logic [BITS_SUM-1:0] sum,
                                                        input logic [BITS_FINE-1:0] code);
        logic [BITS_SUM:0] wide;
        wide = {1'b0, sum} + {{(BITS_SUM + 1 - BITS_FINE){1'b0}}, code};
        return wide[BITS_SUM] ? {BITS_SUM{1'b1}} : wide[BITS_SUM-1:0];
    endfunction

endpackage

// File: rtl/dly_calib_capture_if.sv
// Bus bundle between the calibration controller / pulse generator / TDC
// (master side) and the capture block (slave side).
// Optional feature macro: DLY_CALIB_MINMAX_EN (adds calib_min / calib_max).
interface dly_calib_capture_if;
    import dly_calib_capture_pkg::*;

    logic                      cs_dly_calib;
    logic                      calib_dly;
    logic                      finish_dly_calib;
    logic [CNT_DLY_CALIB-1:0]  cnt_calib_dlyj;
    logic                      tdc_valid;
    logic [BITS_FINE-1:0]      tdc_fine;
    logic [CNT_DLY_CALIB-1:0]  rd_addr;
    logic [BITS_FINE:0]        rd_data;
    logic [BITS_SUM-1:0]       calib_sum;
    logic [CNT_DLY_CALIB-1:0]  calib_n;
    logic [CNT_DLY_CALIB-1:0]  calib_miss;
    logic                      calib_err;
    logic                      calib_busy;
    logic                      calib_done;
`ifdef DLY_CALIB_MINMAX_EN
    logic [BITS_FINE-1:0]      calib_min;
    logic [BITS_FINE-1:0]      calib_max;

    modport master (
        output cs_dly_calib, calib_dly, finish_dly_calib, cnt_calib_dlyj,
               tdc_valid, tdc_fine, rd_addr,
        input  rd_data, calib_sum, calib_n, calib_miss, calib_err,
               calib_busy, calib_done, calib_min, calib_max
    );

    modport slave (
        input  cs_dly_calib, calib_dly, finish_dly_calib, cnt_calib_dlyj,
               tdc_valid, tdc_fine, rd_addr,
        output rd_data, calib_sum, calib_n, calib_miss, calib_err,
               calib_busy, calib_done, calib_min, calib_max
    );
`else
    modport master (
        output cs_dly_calib, calib_dly, finish_dly_calib, cnt_calib_dlyj,
               tdc_valid, tdc_fine, rd_addr,
        input  rd_data, calib_sum, calib_n, calib_miss, calib_err,
               calib_busy, calib_done
    );

    modport slave (
        input  cs_dly_calib, calib_dly, finish_dly_calib, cnt_calib_dlyj,
               tdc_valid, tdc_fine, rd_addr,
        output rd_data, calib_sum, calib_n, calib_miss, calib_err,
               calib_busy, calib_done
    );
`endif

endinterface

// File: rtl/dly_calib_capture_regfile.sv
// Per-step code storage: one entry per calibration pulse, each holding a
// valid bit and the captured fine code. Single write port, registered read
// port, and a clear-all-valid strobe used when a new run is armed.
module dly_calib_regfile
    import dly_calib_capture_pkg::*;
(
    input  logic                     clk_div_enable,
    input  logic                     rst_n,
    input  logic                     clr_valid,
    input  logic                     wr_en,
    input  logic [CNT_DLY_CALIB-1:0] wr_addr,
    input  logic [BITS_FINE-1:0]     wr_code,
    input  logic [CNT_DLY_CALIB-1:0] rd_addr,
    output logic [BITS_FINE:0]       rd_data
);

    logic [BITS_FINE-1:0]       code_mem [BITS_DLY_SWITCH];
    logic [BITS_DLY_SWITCH-1:0] entry_valid;
    logic                       wr_in_range;
    logic                       rd_in_range;

    // Decode whether the write and read addresses land inside the file.
    always_comb begin
        wr_in_range = (wr_addr <= LAST_ENTRY);
        rd_in_range = (rd_addr <= LAST_ENTRY);
    end

    // Valid bits are the only state that must be clean after reset or re-arm.
    always_ff @(posedge clk_div_enable or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid <= '0;
        end else if (clr_valid) begin
            entry_valid <= '0;
        end else if (wr_en && wr_in_range) begin
            entry_valid[wr_addr] <= 1'b1;
        end
    end

    // Code storage needs no reset since invalid entries always read back as zero.
    always_ff @(posedge clk_div_enable) begin
        if (wr_en && wr_in_range) begin
            code_mem[wr_addr] <= wr_code;
        end
    end

    // Registered read: invalid or out-of-range entries return all zeros.
    always_ff @(posedge clk_div_enable or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_in_range && entry_valid[rd_addr]) begin
            rd_data <= {1'b1, code_mem[rd_addr]};
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/dly_calib_capture.sv
// Receive-side partner of the delay-line calibration pulse generator.
// Tags each TDC result with its pulse index, stores it per step and keeps
// sum / count / miss statistics until the run is resolved.
// Optional feature macro: DLY_CALIB_MINMAX_EN (tracks min/max captured code).
module dly_calib_capture
    import dly_calib_capture_pkg::*;
(
    input  logic               clk_div_enable,
    input  logic               rst_n,
    dly_calib_capture_if.slave bus
);

    calib_state_t              state;
    logic                      cs_q;
    logic                      fin_seen;
    logic [CNT_DLY_CALIB-1:0]  tag;
    logic [TIMER_W-1:0]        timer;
    logic [BITS_SUM-1:0]       sum_q;
    logic [CNT_DLY_CALIB-1:0]  n_q;
    logic [CNT_DLY_CALIB-1:0]  miss_q;
    logic                      err_q;
    logic                      busy_q;
    logic                      done_q;
`ifdef DLY_CALIB_MINMAX_EN
    logic [BITS_FINE-1:0]      min_q;
    logic [BITS_FINE-1:0]      max_q;
`endif

    logic arm_start;
    logic aborting;
    logic cap_fire;
    logic cap_in_range;
    logic wr_en;

    // Arm on a rising select, abort on a dropped select, and classify captures.
    always_comb begin
        arm_start    = (state == IDLE) && bus.cs_dly_calib && !cs_q;
        aborting     = ((state == ARMED) || (state == WAIT_RES)) && !bus.cs_dly_calib;
        cap_fire     = (state == WAIT_RES) && !aborting && bus.tdc_valid;
        cap_in_range = (tag <= LAST_ENTRY);
        wr_en        = cap_fire && cap_in_range;
    end

    dly_calib_regfile u_regfile (
        .clk_div_enable (clk_div_enable),
        .rst_n          (rst_n),
        .clr_valid      (arm_start),
        .wr_en          (wr_en),
        .wr_addr        (tag),
        .wr_code        (bus.tdc_fine),
        .rd_addr        (bus.rd_addr),
        .rd_data        (bus.rd_data)
    );

    // Run controller: pulse tagging, result timeout, statistics and status flags.
    always_ff @(posedge clk_div_enable or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cs_q     <= 1'b0;
            fin_seen <= 1'b0;
            tag      <= '0;
            timer    <= '0;
            sum_q    <= '0;
            n_q      <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DLY_CALIB_MINMAX_EN
            min_q    <= {BITS_FINE{1'b1}};
            max_q    <= '0;
`endif
        end else begin
            cs_q <= bus.cs_dly_calib;

            if ((state != IDLE) && bus.finish_dly_calib) begin
                fin_seen <= 1'b1;
            end

            if (wr_en) begin
                sum_q <= sat_add_sum(sum_q, bus.tdc_fine);
                n_q   <= sat_inc_cnt(n_q);
`ifdef DLY_CALIB_MINMAX_EN
                if (bus.tdc_fine < min_q) begin
                    min_q <= bus.tdc_fine;
                end
                if (bus.tdc_fine > max_q) begin
                    max_q <= bus.tdc_fine;
                end
`endif
            end

            if (cap_fire && !cap_in_range) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arm_start) begin
                        state    <= ARMED;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        fin_seen <= 1'b0;
                        sum_q    <= '0;
                        n_q      <= '0;
                        miss_q   <= '0;
                        err_q    <= 1'b0;
`ifdef DLY_CALIB_MINMAX_EN
                        min_q    <= {BITS_FINE{1'b1}};
                        max_q    <= '0;
`endif
                    end
                end

                ARMED: begin
                    if (aborting) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.calib_dly) begin
                        tag   <= bus.cnt_calib_dlyj;
                        timer <= '0;
                        state <= WAIT_RES;
                    end else begin
                        if (bus.tdc_valid) begin
                            err_q <= 1'b1;
                        end
                        if (fin_seen) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end

                WAIT_RES: begin
                    if (aborting) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.calib_dly) begin
                        if (!bus.tdc_valid) begin
                            miss_q <= sat_inc_cnt(miss_q);
                        end
                        tag   <= bus.cnt_calib_dlyj;
                        timer <= '0;
                    end else if (bus.tdc_valid) begin
                        state <= ARMED;
                    end else if (timer == TIMER_LAST) begin
                        miss_q <= sat_inc_cnt(miss_q);
                        state  <= ARMED;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    if (!bus.cs_dly_calib) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.calib_sum  = sum_q;
    assign bus.calib_n    = n_q;
    assign bus.calib_miss = miss_q;
    assign bus.calib_err  = err_q;
    assign bus.calib_busy = busy_q;
    assign bus.calib_done = done_q;
`ifdef DLY_CALIB_MINMAX_EN
    assign bus.calib_min  = min_q;
    assign bus.calib_max  = max_q;
`endif

endmodule
